// File: rtl/prim_steer_pkg.sv
// Shared helpers for the indexed stream demultiplexer: width functions and the
// occupancy type used by anything that tracks per-port FIFO fill levels.
package prim_steer_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int unsigned CNT_MAX_W = 8;
  typedef logic [CNT_MAX_W-1:0] cnt_t;

endpackage

// File: rtl/prim_steer_fifo.sv
// Single-clock FIFO with registered storage and a mux-read head; no bypass, so a
// pushed item becomes visible the cycle after it is written.
module prim_steer_fifo
  import prim_steer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  input  logic          pop_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s, pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign valid_o   = (count_q != '0);
  assign data_o    = mem_q[rptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & valid_o;

  always_comb begin
    wptr_d  = push_ok_s ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok_s  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok_s) mem_q[wptr_q] <= data_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/prim_steer_demux.sv
// Indexed 1:N stream demultiplexer into per-destination FIFOs.
// Optional PRIM_STEER_DEMUX_ERR_EN adds a registered drop pulse and saturating drop counter.
module prim_steer_demux
  import prim_steer_pkg::*;
#(
  parameter int N      = 4,
  parameter int DW     = 32,
  parameter int DEPTH  = 2,
  localparam int IW    = idx_w(N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [IW-1:0]   idx_i,
  input  logic [DW-1:0]   data_i,
  output logic [N-1:0]    valid_o,
  output logic [N*DW-1:0] data_o,
  input  logic [N-1:0]    ready_i,
  output logic            err_o
);

  logic [N-1:0]         full_s;
  logic [N-1:0]         push_s;
  logic [(1<<IW)-1:0]   full_pad_s;
  logic                 in_range_s;

  assign in_range_s = ({1'b0, idx_i} < (IW+1)'(N));

  // Padding keeps the full-flag lookup in bounds when N is not a power of two.
  always_comb begin
    full_pad_s         = '0;
    full_pad_s[N-1:0]  = full_s;
  end

  assign ready_o = in_range_s ? ~full_pad_s[idx_i] : 1'b1;

  for (genvar k = 0; k < N; k++) begin : g_port
    assign push_s[k] = valid_i & ready_o & in_range_s & (idx_i == IW'(k));

    prim_steer_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push_s[k]),
      .data_i  (data_i),
      .full_o  (full_s[k]),
      .pop_i   (ready_i[k]),
      .valid_o (valid_o[k]),
      .data_o  (data_o[k*DW +: DW])
    );
  end

`ifdef PRIM_STEER_DEMUX_ERR_EN
  logic        drop_s;
  logic        err_q;
  logic [15:0] drop_cnt_q;

  assign drop_s = valid_i & ~in_range_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_q      <= 1'b0;
      drop_cnt_q <= 16'h0000;
    end else begin
      err_q <= drop_s;
      if (drop_s && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_steer_demux.sv
// Directed bench: main instance N=4/DW=8/DEPTH=2, plus an N=3 instance for out-of-range drops.
module tb_prim_steer_demux;
  import prim_steer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  idx = 2'd0;
  logic [7:0]  data = 8'h00;
  logic [3:0]  vout;
  logic [31:0] dout;
  logic [3:0]  rdy = 4'b0000;
  logic        err;

  logic        v3 = 1'b0;
  logic        ready3;
  logic [1:0]  idx3 = 2'd0;
  logic [7:0]  d3 = 8'h00;
  logic [2:0]  vout3;
  logic [23:0] dout3;
  logic [2:0]  rdy3 = 3'b000;
  logic        err3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prim_steer_demux #(.N(4), .DW(8), .DEPTH(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .idx_i(idx),
    .data_i(data), .valid_o(vout), .data_o(dout), .ready_i(rdy), .err_o(err)
  );

  prim_steer_demux #(.N(3), .DW(8), .DEPTH(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .valid_i(v3), .ready_o(ready3), .idx_i(idx3),
    .data_i(d3), .valid_o(vout3), .data_o(dout3), .ready_i(rdy3), .err_o(err3)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    cnt_t i;
    tick(); tick();
    check("rst_valid", vout, 4'b0000);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // steering and one-cycle latency
    valid = 1'b1; idx = 2'd2; data = 8'hA5; #1;
    check("steer_ready", ready, 1'b1);
    tick(); valid = 1'b0;
    check("steer_valid", vout, 4'b0100);
    check("steer_data", dout[23:16], 8'hA5);
    check("steer_err", err, 1'b0);

    // fill port 1, then back-pressure only on idx 1
    valid = 1'b1; idx = 2'd1; data = 8'h11; tick();
    data = 8'h22; tick();
    data = 8'h33; #1;
    check("full_ready_idx1", ready, 1'b0);
    idx = 2'd3; data = 8'h44; #1;
    check("full_ready_idx3", ready, 1'b1);
    tick(); valid = 1'b0;
    check("full_valid", vout, 4'b1110);
    check("full_head1", dout[15:8], 8'h11);
    check("full_head3", dout[31:24], 8'h44);
    rdy = 4'b0010; tick();
    check("pop_second", dout[15:8], 8'h22);
    tick();
    check("pop_empty1", vout, 4'b1100);
    rdy = 4'b1100; tick(); rdy = 4'b0000;
    check("drain_all", vout, 4'b0000);

    // full port with a same-cycle pop must still refuse the push
    valid = 1'b1; idx = 2'd0; data = 8'h55; tick();
    data = 8'h66; tick();
    data = 8'h77; rdy = 4'b0001; #1;
    check("fullpop_ready", ready, 1'b0);
    tick(); rdy = 4'b0000; #1;
    check("fullpop_ready_next", ready, 1'b1);
    check("fullpop_head", dout[7:0], 8'h66);
    tick(); valid = 1'b0;
    rdy = 4'b0001; #1;
    check("fullpop_head_keep", dout[7:0], 8'h66);
    tick();
    check("fullpop_third", dout[7:0], 8'h77);
    tick(); rdy = 4'b0000;
    check("fullpop_empty", vout, 4'b0000);

    // pointer wrap with continuous drain on port 3
    rdy = 4'b1000; idx = 2'd3; valid = 1'b1;
    for (i = 8'd0; i < 8'd10; i++) begin
      data = i; #1;
      check("wrap_ready", ready, 1'b1);
      tick();
      check("wrap_valid", vout, 4'b1000);
      check("wrap_data", dout[31:24], i);
    end
    valid = 1'b0; tick(); rdy = 4'b0000;
    check("wrap_drained", vout, 4'b0000);

    // out-of-range index on the N=3 instance is accepted and dropped
    v3 = 1'b1; idx3 = 2'd3; d3 = 8'hFF; #1;
    check("oor_ready", ready3, 1'b1);
    tick(); v3 = 1'b0;
    check("oor_valid", vout3, 3'b000);
`ifdef PRIM_STEER_DEMUX_ERR_EN
    check("oor_err", err3, 1'b1);
    check("oor_cnt", u_dut3.drop_cnt_q, 16'd1);
`else
    check("oor_err", err3, 1'b0);
`endif
    v3 = 1'b1; idx3 = 2'd1; d3 = 8'h5A; tick(); v3 = 1'b0;
    check("oor_err_clear", err3, 1'b0);
    check("n3_valid", vout3, 3'b010);
    check("n3_data", dout3[15:8], 8'h5A);

    // reset with items buffered flushes everything
    valid = 1'b1; idx = 2'd0; data = 8'hC3; tick();
    idx = 2'd2; data = 8'h3C; tick(); valid = 1'b0;
    check("prerst_valid", vout, 4'b0101);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_hold_valid", vout, 4'b0000);
      check("rst_hold_err", err, 1'b0);
      check("rst_hold_data", dout, 32'h0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = 2'(k); #1;
      check("rst_ready", ready, 1'b1);
    end
    tick();
    check("postrst_valid", vout, 4'b0000);
    check("postrst_err", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
